// File: rtl/gshare_predictor_if.sv
// Fetch-side prediction and commit-side update bundle for the gshare predictor.
interface gshare_predictor_if #(
  parameter int unsigned GHR_W = 8
);
  logic             if_valid;
  logic [31:0]      if_pc;
  logic [31:0]      if_inst;
  logic             pred_jump;
  logic [31:0]      pred_pc;
  logic [GHR_W-1:0] pred_ghr;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [GHR_W-1:0] upd_ghr;
  logic             upd_mispredict;
  logic [31:0]      stat_branches;
  logic [31:0]      stat_mispred;

  modport master (
    output if_valid, if_pc, if_inst,
    output upd_valid, upd_pc, upd_taken, upd_ghr, upd_mispredict,
    input  pred_jump, pred_pc, pred_ghr, stat_branches, stat_mispred
  );

  modport slave (
    input  if_valid, if_pc, if_inst,
    input  upd_valid, upd_pc, upd_taken, upd_ghr, upd_mispredict,
    output pred_jump, pred_pc, pred_ghr, stat_branches, stat_mispred
  );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare/bimodal branch predictor: zero-latency prediction for B-type and JAL at fetch,
// speculative global history with commit-time repair, and branch/mispredict counters.
module gshare_predictor #(
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned GHR_W      = 8,
  parameter int unsigned USE_GSHARE = 1,
  parameter int unsigned CNT_INIT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  gshare_predictor_if.slave bp
);

  localparam int unsigned ENTRIES   = 1 << IDX_W;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;

  logic [1:0]       cnt [ENTRIES];
  logic [GHR_W-1:0] ghr;
  logic [GHR_W-1:0] ghr_next;
  logic [31:0]      stat_br_q;
  logic [31:0]      stat_mis_q;

  logic [IDX_W-1:0] f_hist;
  logic [IDX_W-1:0] u_hist;
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] u_idx;
  logic             f_is_b;
  logic             f_is_jal;
  logic             f_taken;
  logic [31:0]      b_imm;
  logic [31:0]      j_imm;
  logic [1:0]       u_cnt;
  logic [1:0]       u_cnt_next;
  logic             repair;
  logic             pred_jump_c;
  logic [31:0]      pred_pc_c;
  logic             unused_upd_pc_bits;

  assign unused_upd_pc_bits = ^{bp.upd_pc[31:IDX_W+2], bp.upd_pc[1:0]};

  // History contribution to the index is dropped entirely in bimodal mode.
  assign f_hist = (USE_GSHARE != 0) ? IDX_W'(ghr)        : '0;
  assign u_hist = (USE_GSHARE != 0) ? IDX_W'(bp.upd_ghr) : '0;
  assign f_idx  = bp.if_pc[IDX_W+1:2]  ^ f_hist;
  assign u_idx  = bp.upd_pc[IDX_W+1:2] ^ u_hist;

  assign f_is_b   = bp.if_valid && (bp.if_inst[6:0] == OP_BRANCH);
  assign f_is_jal = bp.if_valid && (bp.if_inst[6:0] == OP_JAL);
  assign f_taken  = cnt[f_idx][1];

  assign b_imm = {{20{bp.if_inst[31]}}, bp.if_inst[7], bp.if_inst[30:25],
                  bp.if_inst[11:8], 1'b0};
  assign j_imm = {{12{bp.if_inst[31]}}, bp.if_inst[19:12], bp.if_inst[20],
                  bp.if_inst[30:21], 1'b0};

  // Next-PC selection
  always_comb begin
    pred_jump_c = 1'b0;
    pred_pc_c   = bp.if_pc + 32'd4;
    if (f_is_b && f_taken) begin
      pred_jump_c = 1'b1;
      pred_pc_c   = bp.if_pc + b_imm;
    end else if (f_is_jal) begin
      pred_jump_c = 1'b1;
      pred_pc_c   = bp.if_pc + j_imm;
    end
  end

  assign bp.pred_jump     = pred_jump_c;
  assign bp.pred_pc       = pred_pc_c;
  assign bp.pred_ghr      = ghr;
  assign bp.stat_branches = stat_br_q;
  assign bp.stat_mispred  = stat_mis_q;

  // Saturating 2-bit counter step for the committed branch
  always_comb begin
    u_cnt      = cnt[u_idx];
    u_cnt_next = u_cnt;
    if (bp.upd_taken) begin
      if (u_cnt != 2'd3) u_cnt_next = u_cnt + 2'd1;
    end else begin
      if (u_cnt != 2'd0) u_cnt_next = u_cnt - 2'd1;
    end
  end

  // A mispredict repair rebuilds history from the branch's own snapshot and
  // overrides any speculative shift from a same-cycle fetch.
  assign repair = bp.upd_valid && bp.upd_mispredict;

  always_comb begin
    ghr_next = ghr;
    if (repair) begin
      ghr_next = GHR_W'({bp.upd_ghr, bp.upd_taken});
    end else if (f_is_b) begin
      ghr_next = GHR_W'({ghr, f_taken});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        cnt[i] <= 2'(CNT_INIT);
      end
      ghr        <= '0;
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else if (rdy) begin
      if (bp.upd_valid) begin
        cnt[u_idx] <= u_cnt_next;
      end
      ghr        <= ghr_next;
      stat_br_q  <= stat_br_q + 32'(bp.upd_valid);
      stat_mis_q <= stat_mis_q + 32'(repair);
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: directed vector table, hand sequences for counter saturation
// and history repair, then randomized traffic against an array-based reference model.
module tb_gshare_predictor;

  localparam logic [31:0] B16   = 32'h0000_0863; // beq +16
  localparam logic [31:0] BM8   = 32'hFE00_0CE3; // beq -8
  localparam logic [31:0] JAL32 = 32'h0200_006F; // jal +32
  localparam logic [31:0] JALR  = 32'h0000_8067;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  always #5 clk = ~clk;

  gshare_predictor_if #(.GHR_W(8)) bp_g ();
  gshare_predictor_if #(.GHR_W(8)) bp_b ();

  assign bp_b.if_valid       = bp_g.if_valid;
  assign bp_b.if_pc          = bp_g.if_pc;
  assign bp_b.if_inst        = bp_g.if_inst;
  assign bp_b.upd_valid      = bp_g.upd_valid;
  assign bp_b.upd_pc         = bp_g.upd_pc;
  assign bp_b.upd_taken      = bp_g.upd_taken;
  assign bp_b.upd_ghr        = bp_g.upd_ghr;
  assign bp_b.upd_mispredict = bp_g.upd_mispredict;

  gshare_predictor #(.IDX_W(8), .GHR_W(8), .USE_GSHARE(1), .CNT_INIT(1)) dut_g (
    .clk(clk), .rst(rst), .rdy(rdy), .bp(bp_g));
  gshare_predictor #(.IDX_W(8), .GHR_W(8), .USE_GSHARE(0), .CNT_INIT(1)) dut_b (
    .clk(clk), .rst(rst), .rdy(rdy), .bp(bp_b));

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 = gshare instance, 1 = bimodal instance
  int          mcnt [2][256];
  int          mghr [2];
  int unsigned mbr;
  int unsigned mmis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int b_off(input logic [31:0] i);
    int v;
    v = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048 + int'(i[31]) * 4096;
    if (i[31]) v -= 8192;
    return v;
  endfunction

  function automatic int j_off(input logic [31:0] i);
    int v;
    v = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096 + int'(i[31]) * (1 << 20);
    if (i[31]) v -= (1 << 21);
    return v;
  endfunction

  function automatic void mpred(input int m, output bit jump, output logic [31:0] npc,
                                output bit is_b, output bit taken);
    int idx;
    jump  = 1'b0;
    npc   = bp_g.if_pc + 32'd4;
    is_b  = 1'b0;
    taken = 1'b0;
    if (bp_g.if_valid) begin
      if (bp_g.if_inst[6:0] == 7'h63) begin
        is_b = 1'b1;
        idx  = int'((bp_g.if_pc >> 2) & 32'hFF);
        if (m == 0) idx = idx ^ mghr[0];
        taken = (mcnt[m][idx] >= 2);
        if (taken) begin
          jump = 1'b1;
          npc  = bp_g.if_pc + b_off(bp_g.if_inst);
        end
      end else if (bp_g.if_inst[6:0] == 7'h6F) begin
        jump = 1'b1;
        npc  = bp_g.if_pc + j_off(bp_g.if_inst);
      end
    end
  endfunction

  function automatic void model_clock();
    bit jump, is_b, taken;
    logic [31:0] npc;
    int idx;
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < 256; k++) mcnt[m][k] = 1;
        mghr[m] = 0;
      end
      mbr  = 0;
      mmis = 0;
    end else if (rdy) begin
      for (int m = 0; m < 2; m++) begin
        mpred(m, jump, npc, is_b, taken);
        if (bp_g.upd_valid && bp_g.upd_mispredict)
          mghr[m] = ((int'(bp_g.upd_ghr) << 1) | int'(bp_g.upd_taken)) & 255;
        else if (is_b)
          mghr[m] = ((mghr[m] << 1) | int'(taken)) & 255;
        if (bp_g.upd_valid) begin
          idx = int'((bp_g.upd_pc >> 2) & 32'hFF);
          if (m == 0) idx = idx ^ int'(bp_g.upd_ghr);
          if (bp_g.upd_taken) mcnt[m][idx] = (mcnt[m][idx] < 3) ? mcnt[m][idx] + 1 : 3;
          else                mcnt[m][idx] = (mcnt[m][idx] > 0) ? mcnt[m][idx] - 1 : 0;
        end
      end
      if (bp_g.upd_valid) mbr++;
      if (bp_g.upd_valid && bp_g.upd_mispredict) mmis++;
    end
  endfunction

  task automatic check_all(input string tag);
    bit jump, is_b, taken;
    logic [31:0] npc;
    mpred(0, jump, npc, is_b, taken);
    check({tag, ".g.jump"}, 32'(bp_g.pred_jump), 32'(jump));
    check({tag, ".g.pc"},   bp_g.pred_pc, npc);
    check({tag, ".g.ghr"},  32'(bp_g.pred_ghr), 32'(mghr[0]));
    check({tag, ".g.br"},   bp_g.stat_branches, mbr);
    check({tag, ".g.mis"},  bp_g.stat_mispred, mmis);
    mpred(1, jump, npc, is_b, taken);
    check({tag, ".b.jump"}, 32'(bp_b.pred_jump), 32'(jump));
    check({tag, ".b.pc"},   bp_b.pred_pc, npc);
    check({tag, ".b.ghr"},  32'(bp_b.pred_ghr), 32'(mghr[1]));
    check({tag, ".b.br"},   bp_b.stat_branches, mbr);
    check({tag, ".b.mis"},  bp_b.stat_mispred, mmis);
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [7:0] ughr, input logic um);
    rdy                 = r;
    bp_g.if_valid       = iv;
    bp_g.if_pc          = pc;
    bp_g.if_inst        = inst;
    bp_g.upd_valid      = uv;
    bp_g.upd_pc         = upc;
    bp_g.upd_taken      = ut;
    bp_g.upd_ghr        = ughr;
    bp_g.upd_mispredict = um;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0, NOP, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken);
    drive(1'b1, 1'b0, 32'h0, NOP, 1'b1, pc, taken, 8'h00, 1'b0);
    tick();
  endtask

  // Frozen probe: outputs are combinational, so rdy=0 lets us observe without disturbing state
  task automatic probe(input string name, input logic [31:0] pc, input logic ej, input logic [31:0] epc);
    drive(1'b0, 1'b1, pc, B16, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0);
    @(negedge clk);
    check({name, ".jump"}, 32'(bp_g.pred_jump), 32'(ej));
    check({name, ".pc"}, bp_g.pred_pc, epc);
    check_all(name);
    tick();
  endtask

  typedef struct {
    logic        rdy;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [7:0]  ughr;
    logic        um;
    logic        ej;
    logic [31:0] epc;
    logic [7:0]  eghr;
    logic [31:0] ebr;
    logic [31:0] emis;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 32'h100, B16,   1'b0, 32'h0,   1'b0, 8'h00, 1'b0, 1'b0, 32'h104, 8'h00, 32'd0, 32'd0};
    tbl[1]  = '{1'b1, 1'b0, 32'h200, NOP,   1'b1, 32'h100, 1'b1, 8'h00, 1'b0, 1'b0, 32'h204, 8'h00, 32'd0, 32'd0};
    tbl[2]  = '{1'b1, 1'b0, 32'h200, NOP,   1'b1, 32'h100, 1'b1, 8'h00, 1'b0, 1'b0, 32'h204, 8'h00, 32'd1, 32'd0};
    tbl[3]  = '{1'b1, 1'b1, 32'h100, B16,   1'b0, 32'h0,   1'b0, 8'h00, 1'b0, 1'b1, 32'h110, 8'h00, 32'd2, 32'd0};
    tbl[4]  = '{1'b1, 1'b1, 32'h100, B16,   1'b0, 32'h0,   1'b0, 8'h00, 1'b0, 1'b0, 32'h104, 8'h01, 32'd2, 32'd0};
    tbl[5]  = '{1'b1, 1'b1, 32'h300, JAL32, 1'b0, 32'h0,   1'b0, 8'h00, 1'b0, 1'b1, 32'h320, 8'h02, 32'd2, 32'd0};
    tbl[6]  = '{1'b1, 1'b1, 32'h300, JALR,  1'b0, 32'h0,   1'b0, 8'h00, 1'b0, 1'b0, 32'h304, 8'h02, 32'd2, 32'd0};
    tbl[7]  = '{1'b1, 1'b1, 32'h100, B16,   1'b1, 32'h400, 1'b1, 8'h05, 1'b1, 1'b0, 32'h104, 8'h02, 32'd2, 32'd0};
    tbl[8]  = '{1'b0, 1'b1, 32'h014, B16,   1'b1, 32'h100, 1'b1, 8'h00, 1'b1, 1'b0, 32'h018, 8'h0B, 32'd3, 32'd1};
    tbl[9]  = '{1'b1, 1'b0, 32'h000, NOP,   1'b0, 32'h0,   1'b0, 8'h00, 1'b0, 1'b0, 32'h004, 8'h0B, 32'd3, 32'd1};
    tbl[10] = '{1'b1, 1'b0, 32'h020, NOP,   1'b0, 32'h0,   1'b1, 8'hFF, 1'b1, 1'b0, 32'h024, 8'h0B, 32'd3, 32'd1};
    tbl[11] = '{1'b1, 1'b1, 32'h200, BM8,   1'b0, 32'h0,   1'b0, 8'h00, 1'b0, 1'b0, 32'h204, 8'h0B, 32'd3, 32'd1};
    tbl[12] = '{1'b1, 1'b1, 32'h04C, BM8,   1'b0, 32'h0,   1'b0, 8'h00, 1'b0, 1'b1, 32'h044, 8'h16, 32'd3, 32'd1};

    do_reset();
    @(negedge clk);
    check("reset.ghr", 32'(bp_g.pred_ghr), 32'h0);
    check("reset.br", bp_g.stat_branches, 32'h0);
    check("reset.mis", bp_g.stat_mispred, 32'h0);

    // Directed vectors from reset
    foreach (tbl[i]) begin
      drive(tbl[i].rdy, tbl[i].iv, tbl[i].pc, tbl[i].inst, tbl[i].uv, tbl[i].upc,
            tbl[i].ut, tbl[i].ughr, tbl[i].um);
      @(negedge clk);
      check($sformatf("vec%0d.jump", i), 32'(bp_g.pred_jump), 32'(tbl[i].ej));
      check($sformatf("vec%0d.pc", i), bp_g.pred_pc, tbl[i].epc);
      check($sformatf("vec%0d.ghr", i), 32'(bp_g.pred_ghr), 32'(tbl[i].eghr));
      check($sformatf("vec%0d.br", i), bp_g.stat_branches, tbl[i].ebr);
      check($sformatf("vec%0d.mis", i), bp_g.stat_mispred, tbl[i].emis);
      check_all($sformatf("vec%0d", i));
      tick();
    end

    // Gshare ghr is now 0x2D so it indexes an untrained entry; bimodal hits the trained one
    drive(1'b0, 1'b1, 32'h100, B16, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0);
    @(negedge clk);
    check("mode.g.pc", bp_g.pred_pc, 32'h104);
    check("mode.b.pc", bp_b.pred_pc, 32'h110);
    check("mode.g.ghr", 32'(bp_g.pred_ghr), 32'h2D);
    tick();

    // Saturation: 5 taken from 1 must hold at 3, then one not-taken still predicts taken
    do_reset();
    for (int k = 0; k < 5; k++) upd(32'h100, 1'b1);
    probe("sat3.a", 32'h100, 1'b1, 32'h110);
    upd(32'h100, 1'b0);
    probe("sat3.b", 32'h100, 1'b1, 32'h110);
    upd(32'h100, 1'b0);
    probe("sat3.c", 32'h100, 1'b0, 32'h104);
    for (int k = 0; k < 4; k++) upd(32'h100, 1'b0);
    upd(32'h100, 1'b1);
    probe("sat0.a", 32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b1);
    probe("sat0.b", 32'h100, 1'b1, 32'h110);

    // History repair after three not-taken fetches
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 32'h200 + 32'(k * 4), B16, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0);
      tick();
    end
    @(negedge clk);
    check("repair.pre", 32'(bp_g.pred_ghr), 32'h00);
    drive(1'b1, 1'b0, 32'h0, NOP, 1'b1, 32'h100, 1'b1, 8'h05, 1'b1);
    tick();
    @(negedge clk);
    check("repair.post", 32'(bp_g.pred_ghr), 32'h0B);
    check("repair.mis", bp_g.stat_mispred, 32'h1);

    // Randomized traffic against the model, including resets and stalls
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] inst;
      case ($urandom_range(0, 5))
        0, 1:    inst = ($urandom & 32'hFFFF_FF80) | 32'h63;
        2:       inst = ($urandom & 32'hFFFF_FF80) | 32'h6F;
        3:       inst = ($urandom & 32'hFFFF_FF80) | 32'h67;
        4:       inst = $urandom;
        default: inst = NOP;
      endcase
      rst = ($urandom_range(0, 199) == 0);
      drive(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), $urandom & 32'h0000_0FFF, inst,
            1'($urandom_range(0, 1)), $urandom & 32'h0000_0FFF, ($urandom_range(0, 9) < 7),
            8'($urandom), ($urandom_range(0, 3) == 0));
      @(negedge clk);
      check_all($sformatf("rnd%0d", n));
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
